// File: rtl/pla_harness_pkg.sv
// Shared types and default sizes for the PLA vector driver harness.
// Contents:
//   N_IN     - default width of the core input vector
//   CNT_W    - default width of the result/error counters
//   SETTLE_W - width of the settle down-counter (settle range 1..15)
//   state_t  - driver FSM states
//   mode_t   - run mode latched at start
package pla_harness_pkg;

   localparam int unsigned N_IN     = 21;
   localparam int unsigned CNT_W    = 32;
   localparam int unsigned SETTLE_W = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      OUT    = 3'd3,
      DONE   = 3'd4
   } state_t;

   typedef enum logic {
      MODE_STREAM = 1'b0,
      MODE_SWEEP  = 1'b1
   } mode_t;

endpackage

// File: rtl/pla_sweep_counter.sv
// Exhaustive sweep source for the PLA driver: an N_IN-bit counter with
// synchronous clear and increment, plus a registered all-ones flag.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - return the counter to zero
//   inc       - advance the counter by one (clear has priority)
//   value     - current sweep vector
//   terminal  - high while value is all ones
module pla_sweep_counter #(
   parameter int unsigned N_IN = 21
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            inc,
   output logic [N_IN-1:0] value,
   output logic            terminal
);

   logic [N_IN-1:0] value_inc;

   assign value_inc = value + N_IN'(1);

   // terminal tracks the stored value so the caller can test it before
   // asking for the increment that would otherwise wrap to zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value    <= '0;
         terminal <= 1'b0;
      end else if (clear) begin
         value    <= '0;
         terminal <= 1'b0;
      end else if (inc) begin
         value    <= value_inc;
         terminal <= &value_inc;
      end
   end

endmodule

// File: rtl/pla_vector_driver.sv
// Stimulus/response stage in front of a combinational PLA core. Drives one
// vector at a time onto the core inputs, waits a programmable settle time,
// samples the core output and presents it as a result with an optional
// expected-value check. Vectors come from a valid/ready stream or from an
// internal exhaustive sweep.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   start, mode                   - begin a run (IDLE/DONE only); 0 stream, 1 sweep
//   in_valid/in_ready/in_vec/
//   in_exp/in_last                - stream vector input with expected output
//   x_out                         - drive to core inputs (bit i -> xi)
//   y_in                          - core output
//   res_valid/res_ready/res_vec/
//   res_y/res_mismatch            - result output
//   busy, done                    - run status
//   vec_count, err_count          - accepted results / accepted mismatches
module pla_vector_driver #(
   parameter int unsigned N_IN   = pla_harness_pkg::N_IN,
   parameter int unsigned CNT_W  = pla_harness_pkg::CNT_W,
   parameter int unsigned SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_vec,
   input  logic             in_exp,
   input  logic             in_last,
   output logic [N_IN-1:0]  x_out,
   input  logic             y_in,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [N_IN-1:0]  res_vec,
   output logic             res_y,
   output logic             res_mismatch,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count
);

   typedef pla_harness_pkg::state_t state_t;
   typedef pla_harness_pkg::mode_t  mode_t;

   localparam int unsigned SETTLE_W = pla_harness_pkg::SETTLE_W;
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

   state_t              state;
   state_t              state_next;
   mode_t               mode_q;
   logic [N_IN-1:0]     stream_vec;
   logic                exp_q;
   logic                last_q;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [N_IN-1:0]     sweep_val;
   logic                sweep_terminal;

   logic                start_run;
   logic                sweep_clear;
   logic                sweep_inc;
   logic                accept_in;
   logic                sample;
   logic                accept_res;

   // Sweep vector source
   pla_sweep_counter #(
      .N_IN (N_IN)
   ) u_sweep (
      .clk      (clk),
      .rst      (rst),
      .clear    (sweep_clear),
      .inc      (sweep_inc),
      .value    (sweep_val),
      .terminal (sweep_terminal)
   );

   // Core drive: both sources are registers and mode_q only changes at start
   assign x_out = (mode_q == pla_harness_pkg::MODE_SWEEP) ? sweep_val : stream_vec;

   // Next-state and per-cycle event decode
   always_comb begin
      state_next  = state;
      start_run   = 1'b0;
      sweep_clear = 1'b0;
      sweep_inc   = 1'b0;
      accept_in   = 1'b0;
      sample      = 1'b0;
      accept_res  = 1'b0;
      unique case (state)
         pla_harness_pkg::IDLE,
         pla_harness_pkg::DONE: begin
            if (start) begin
               start_run   = 1'b1;
               sweep_clear = 1'b1;
               state_next  = mode ? pla_harness_pkg::SETTLE : pla_harness_pkg::LOAD;
            end
         end
         pla_harness_pkg::LOAD: begin
            if (in_valid && in_ready) begin
               accept_in  = 1'b1;
               state_next = pla_harness_pkg::SETTLE;
            end
         end
         pla_harness_pkg::SETTLE: begin
            if (settle_cnt == '0) begin
               sample     = 1'b1;
               state_next = pla_harness_pkg::OUT;
            end
         end
         pla_harness_pkg::OUT: begin
            if (res_ready) begin
               accept_res = 1'b1;
               if (mode_q == pla_harness_pkg::MODE_STREAM) begin
                  state_next = last_q ? pla_harness_pkg::DONE : pla_harness_pkg::LOAD;
               end else if (sweep_terminal) begin
                  state_next = pla_harness_pkg::DONE;
               end else begin
                  sweep_inc  = 1'b1;
                  state_next = pla_harness_pkg::SETTLE;
               end
            end
         end
         default: state_next = pla_harness_pkg::IDLE;
      endcase
   end

   // State register and status flags decoded from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= pla_harness_pkg::IDLE;
         in_ready  <= 1'b0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_next;
         in_ready  <= (state_next == pla_harness_pkg::LOAD);
         res_valid <= (state_next == pla_harness_pkg::OUT);
         busy      <= !((state_next == pla_harness_pkg::IDLE) ||
                        (state_next == pla_harness_pkg::DONE));
         done      <= (state_next == pla_harness_pkg::DONE);
      end
   end

   // Run mode and stream vector capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= pla_harness_pkg::MODE_STREAM;
         stream_vec <= '0;
         exp_q      <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         if (start_run) begin
            mode_q <= mode_t'(mode);
         end
         if (accept_in) begin
            stream_vec <= in_vec;
            exp_q      <= in_exp;
            last_q     <= in_last;
         end
      end
   end

   // Settle timer: loaded on entry to SETTLE, sample when it reads zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settle_cnt <= '0;
      end else if ((state_next == pla_harness_pkg::SETTLE) &&
                   (state != pla_harness_pkg::SETTLE)) begin
         settle_cnt <= SETTLE_LOAD;
      end else if ((state == pla_harness_pkg::SETTLE) && (settle_cnt != '0)) begin
         settle_cnt <= settle_cnt - SETTLE_W'(1);
      end
   end

   // Result capture; held unchanged through OUT until accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_vec      <= '0;
         res_y        <= 1'b0;
         res_mismatch <= 1'b0;
      end else if (sample) begin
         res_vec      <= x_out;
         res_y        <= y_in;
         res_mismatch <= (y_in ^ exp_q) & (mode_q == pla_harness_pkg::MODE_STREAM);
      end
   end

   // Saturating result and error counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_count <= '0;
         err_count <= '0;
      end else if (start_run) begin
         vec_count <= '0;
         err_count <= '0;
      end else if (accept_res) begin
         if (vec_count != '1) begin
            vec_count <= vec_count + CNT_W'(1);
         end
         if (res_mismatch && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pla_vector_driver.sv
// Directed bench for pla_vector_driver. Three instances:
//   a: N_IN=21, SETTLE=1, stub y = x1 & ~x3 & ~x0 & ~x2 & ~x4 (stream tests)
//   b: N_IN=4,  SETTLE=1, stub y = x0 (exhaustive sweep)
//   c: N_IN=4,  SETTLE=3, CNT_W=2, stub y = x0 delayed two cycles
module tb_pla_vector_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   // instance a
   logic        a_start, a_mode, a_in_valid, a_in_ready, a_in_exp, a_in_last;
   logic        a_y, a_res_valid, a_res_ready, a_res_y, a_res_mismatch, a_busy, a_done;
   logic [20:0] a_in_vec, a_x_out, a_res_vec;
   logic [31:0] a_vec_count, a_err_count;

   // instance b
   logic        b_start, b_mode, b_in_valid, b_in_ready, b_in_exp, b_in_last;
   logic        b_y, b_res_valid, b_res_ready, b_res_y, b_res_mismatch, b_busy, b_done;
   logic [3:0]  b_in_vec, b_x_out, b_res_vec;
   logic [31:0] b_vec_count, b_err_count;

   // instance c
   logic        c_start, c_mode, c_in_valid, c_in_ready, c_in_exp, c_in_last;
   logic        c_y, c_res_valid, c_res_ready, c_res_y, c_res_mismatch, c_busy, c_done;
   logic [3:0]  c_in_vec, c_x_out, c_res_vec;
   logic [1:0]  c_vec_count, c_err_count;
   logic        c_d1, c_d2;

   assign a_y = a_x_out[1] & ~a_x_out[3] & ~a_x_out[0] & ~a_x_out[2] & ~a_x_out[4];
   assign b_y = b_x_out[0];
   assign c_y = c_d2;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         c_d1 <= 1'b0;
         c_d2 <= 1'b0;
      end else begin
         c_d1 <= c_x_out[0];
         c_d2 <= c_d1;
      end
   end

   pla_vector_driver #(.N_IN(21), .CNT_W(32), .SETTLE(1)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .mode(a_mode),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
      .in_exp(a_in_exp), .in_last(a_in_last), .x_out(a_x_out), .y_in(a_y),
      .res_valid(a_res_valid), .res_ready(a_res_ready), .res_vec(a_res_vec),
      .res_y(a_res_y), .res_mismatch(a_res_mismatch), .busy(a_busy),
      .done(a_done), .vec_count(a_vec_count), .err_count(a_err_count));

   pla_vector_driver #(.N_IN(4), .CNT_W(32), .SETTLE(1)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .mode(b_mode),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
      .in_exp(b_in_exp), .in_last(b_in_last), .x_out(b_x_out), .y_in(b_y),
      .res_valid(b_res_valid), .res_ready(b_res_ready), .res_vec(b_res_vec),
      .res_y(b_res_y), .res_mismatch(b_res_mismatch), .busy(b_busy),
      .done(b_done), .vec_count(b_vec_count), .err_count(b_err_count));

   pla_vector_driver #(.N_IN(4), .CNT_W(2), .SETTLE(3)) u_c (
      .clk(clk), .rst(rst), .start(c_start), .mode(c_mode),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_vec(c_in_vec),
      .in_exp(c_in_exp), .in_last(c_in_last), .x_out(c_x_out), .y_in(c_y),
      .res_valid(c_res_valid), .res_ready(c_res_ready), .res_vec(c_res_vec),
      .res_y(c_res_y), .res_mismatch(c_res_mismatch), .busy(c_busy),
      .done(c_done), .vec_count(c_vec_count), .err_count(c_err_count));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // kind: 0 res_valid, 1 done, 2 in_ready
   function automatic logic flag(input int dut, input int kind);
      logic [2:0] v;
      case (dut)
         0:       v = {a_in_ready, a_done, a_res_valid};
         1:       v = {b_in_ready, b_done, b_res_valid};
         default: v = {c_in_ready, c_done, c_res_valid};
      endcase
      return v[2'(kind)];
   endfunction

   task automatic wait_for(input int dut, input int kind, input string tag);
      int n = 0;
      while (!flag(dut, kind) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(flag(dut, kind)), 32'd1);
   endtask

   initial begin
      logic [3:0] v;
      rst = 1'b1;
      a_start = 0; a_mode = 0; a_in_valid = 0; a_in_vec = '0; a_in_exp = 0; a_in_last = 0; a_res_ready = 0;
      b_start = 0; b_mode = 0; b_in_valid = 0; b_in_vec = '0; b_in_exp = 0; b_in_last = 0; b_res_ready = 0;
      c_start = 0; c_mode = 0; c_in_valid = 0; c_in_vec = '0; c_in_exp = 0; c_in_last = 0; c_res_ready = 0;
      repeat (2) @(negedge clk);

      // reset values
      chk("rst_x_out",     32'(a_x_out), 32'd0);
      chk("rst_res_vec",   32'(a_res_vec), 32'd0);
      chk("rst_res_y",     32'(a_res_y), 32'd0);
      chk("rst_mismatch",  32'(a_res_mismatch), 32'd0);
      chk("rst_res_valid", 32'(a_res_valid), 32'd0);
      chk("rst_in_ready",  32'(a_in_ready), 32'd0);
      chk("rst_busy",      32'(a_busy), 32'd0);
      chk("rst_done",      32'(a_done), 32'd0);
      chk("rst_vec_count", a_vec_count, 32'd0);
      chk("rst_err_count", a_err_count, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // stream run, first vector 0x00002 exp 1
      a_mode = 1'b0; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      chk("load_in_ready", 32'(a_in_ready), 32'd1);
      chk("load_busy",     32'(a_busy), 32'd1);
      a_in_vec = 21'h00002; a_in_exp = 1'b1; a_in_last = 1'b0; a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      chk("v1_x_out",     32'(a_x_out), 32'h2);
      chk("v1_ready_low", 32'(a_in_ready), 32'd0);
      chk("v1_settle",    32'(a_res_valid), 32'd0);
      @(negedge clk);
      chk("v1_res_valid", 32'(a_res_valid), 32'd1);
      chk("v1_res_y",     32'(a_res_y), 32'd1);
      chk("v1_mismatch",  32'(a_res_mismatch), 32'd0);
      chk("v1_res_vec",   32'(a_res_vec), 32'h2);

      // backpressure: results held, counters frozen
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_res_valid", 32'(a_res_valid), 32'd1);
         chk("bp_res_vec",   32'(a_res_vec), 32'h2);
         chk("bp_res_y",     32'(a_res_y), 32'd1);
         chk("bp_vec_count", a_vec_count, 32'd0);
         chk("bp_in_ready",  32'(a_in_ready), 32'd0);
      end
      a_res_ready = 1'b1;
      @(negedge clk);
      a_res_ready = 1'b0;
      chk("bp_count_after", a_vec_count, 32'd1);
      chk("bp_valid_after", 32'(a_res_valid), 32'd0);
      chk("bp_back_load",   32'(a_in_ready), 32'd1);

      // second vector 0x00000 exp 1, last
      a_in_vec = 21'h00000; a_in_exp = 1'b1; a_in_last = 1'b1; a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0; a_in_last = 1'b0;
      @(negedge clk);
      chk("v2_res_valid", 32'(a_res_valid), 32'd1);
      chk("v2_res_y",     32'(a_res_y), 32'd0);
      chk("v2_mismatch",  32'(a_res_mismatch), 32'd1);
      chk("v2_res_vec",   32'(a_res_vec), 32'h0);
      a_res_ready = 1'b1;
      @(negedge clk);
      a_res_ready = 1'b0;
      chk("s_done",      32'(a_done), 32'd1);
      chk("s_busy",      32'(a_busy), 32'd0);
      chk("s_vec_count", a_vec_count, 32'd2);
      chk("s_err_count", a_err_count, 32'd1);
      chk("s_res_valid", 32'(a_res_valid), 32'd0);
      chk("s_in_ready",  32'(a_in_ready), 32'd0);
      @(negedge clk);
      chk("s_hold_vec",  a_vec_count, 32'd2);
      chk("s_hold_done", 32'(a_done), 32'd1);

      // restart clears counters; start/mode while busy are ignored
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      chk("rs_vec_count", a_vec_count, 32'd0);
      chk("rs_err_count", a_err_count, 32'd0);
      a_mode = 1'b1; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0; a_mode = 1'b0;
      chk("ign_in_ready",  32'(a_in_ready), 32'd1);
      chk("ign_busy",      32'(a_busy), 32'd1);
      chk("ign_res_valid", 32'(a_res_valid), 32'd0);

      // reset while in SETTLE
      a_in_vec = 21'h10002; a_in_exp = 1'b0; a_in_last = 1'b1; a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0; a_in_last = 1'b0;
      chk("mid_x_out", 32'(a_x_out), 32'h10002);
      rst = 1'b1;
      #1;
      chk("mid_rst_x_out",     32'(a_x_out), 32'd0);
      chk("mid_rst_busy",      32'(a_busy), 32'd0);
      chk("mid_rst_in_ready",  32'(a_in_ready), 32'd0);
      chk("mid_rst_res_valid", 32'(a_res_valid), 32'd0);
      @(negedge clk);
      chk("mid_rst_hold_valid", 32'(a_res_valid), 32'd0);
      chk("mid_rst_hold_y",     32'(a_res_y), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      a_in_vec = 21'h00002; a_in_exp = 1'b1; a_in_last = 1'b1; a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0; a_in_last = 1'b0;
      @(negedge clk);
      chk("pr_res_valid", 32'(a_res_valid), 32'd1);
      chk("pr_res_y",     32'(a_res_y), 32'd1);
      chk("pr_mismatch",  32'(a_res_mismatch), 32'd0);
      a_res_ready = 1'b1;
      @(negedge clk);
      a_res_ready = 1'b0;
      chk("pr_done",      32'(a_done), 32'd1);
      chk("pr_vec_count", a_vec_count, 32'd1);
      chk("pr_err_count", a_err_count, 32'd0);

      // exhaustive sweep on 4 inputs, stub y = x0
      b_res_ready = 1'b1; b_mode = 1'b1; b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0; b_mode = 1'b0;
      chk("sw_busy",     32'(b_busy), 32'd1);
      chk("sw_in_ready", 32'(b_in_ready), 32'd0);
      chk("sw_x_out",    32'(b_x_out), 32'd0);
      for (int i = 0; i < 16; i++) begin
         wait_for(1, 0, "sw_res_wait");
         chk("sw_res_vec",  32'(b_res_vec), 32'(i));
         chk("sw_res_y",    32'(b_res_y), 32'(i % 2));
         chk("sw_mismatch", 32'(b_res_mismatch), 32'd0);
         chk("sw_in_ready_low", 32'(b_in_ready), 32'd0);
         @(negedge clk);
      end
      wait_for(1, 1, "sw_done_wait");
      chk("sw_vec_count", b_vec_count, 32'd16);
      chk("sw_err_count", b_err_count, 32'd0);
      chk("sw_final_x",   32'(b_x_out), 32'hF);
      chk("sw_end_valid", 32'(b_res_valid), 32'd0);
      chk("sw_end_busy",  32'(b_busy), 32'd0);

      // SETTLE=3 with a two-cycle stub, then counter saturation (CNT_W=2)
      c_res_ready = 1'b1; c_mode = 1'b0; c_start = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      wait_for(2, 2, "c_ready_wait");
      c_in_vec = 4'h1; c_in_exp = 1'b1; c_in_last = 1'b0; c_in_valid = 1'b1;
      @(negedge clk);
      c_in_valid = 1'b0;
      chk("c_lat1", 32'(c_res_valid), 32'd0);
      @(negedge clk);
      chk("c_lat2", 32'(c_res_valid), 32'd0);
      @(negedge clk);
      chk("c_lat3", 32'(c_res_valid), 32'd0);
      @(negedge clk);
      chk("c_lat4_valid", 32'(c_res_valid), 32'd1);
      chk("c_post_change_y", 32'(c_res_y), 32'd1);
      chk("c_first_mismatch", 32'(c_res_mismatch), 32'd0);
      @(negedge clk);
      chk("c_vec_count1", 32'(c_vec_count), 32'd1);
      for (int i = 0; i < 4; i++) begin
         v = 4'(i % 2);
         wait_for(2, 2, "c_ready_wait");
         c_in_vec = v; c_in_exp = ~v[0]; c_in_last = (i == 3); c_in_valid = 1'b1;
         @(negedge clk);
         c_in_valid = 1'b0; c_in_last = 1'b0;
         wait_for(2, 0, "c_res_wait");
         chk("c_res_vec",  32'(c_res_vec), 32'(v));
         chk("c_res_y",    32'(c_res_y), 32'(v[0]));
         chk("c_mismatch", 32'(c_res_mismatch), 32'd1);
         @(negedge clk);
      end
      wait_for(2, 1, "c_done_wait");
      chk("c_err_sat", 32'(c_err_count), 32'd3);
      chk("c_vec_sat", 32'(c_vec_count), 32'd3);
      chk("c_busy_end", 32'(c_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
